// File: rtl/dsp_post_adder_acc.sv
// dsp_post_adder_acc: DSP slice P stage, X/Z operand select, add/subtract with carry, P register and cascade
module dsp_post_adder_acc #(
    parameter int WIDTH      = 48,
    parameter int M_WIDTH    = 36,
    parameter bit OPMODEREG  = 1,
    parameter bit CREG       = 1,
    parameter bit CARRYINREG = 1,
    parameter bit PREG       = 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [M_WIDTH-1:0] M,
    input  logic [WIDTH-1:0]   C,
    input  logic [WIDTH-1:0]   PCIN,
    input  logic [WIDTH-1:0]   DAB,
    input  logic               CARRYIN,
    input  logic [7:0]         OPMODE,
    input  logic               CEOPMODE,
    input  logic               CEC,
    input  logic               CECARRYIN,
    input  logic               CEP,
    output logic [WIDTH-1:0]   P,
    output logic [WIDTH-1:0]   PCOUT,
    output logic               CARRYOUT,
    output logic               CARRYOUTF
);
    logic [7:0]       opmode_eff;
    logic [WIDTH-1:0] c_eff;
    logic             cin_eff;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] z;
    logic [WIDTH:0]   s;
    logic             unused_opmode;

    assign unused_opmode = ^opmode_eff[6:4];

    generate
        if (OPMODEREG) begin : g_opmode_reg
            logic [7:0] opmode_q;
            logic [7:0] opmode_d;
            assign opmode_d   = CEOPMODE ? OPMODE : opmode_q;
            assign opmode_eff = opmode_q;
            // OPMODE pipeline register, held while its enable is low
            always_ff @(posedge CLK or negedge RST)
                if (!RST) opmode_q <= '0;
                else      opmode_q <= opmode_d;
        end else begin : g_opmode_byp
            assign opmode_eff = OPMODE;
        end

        if (CREG) begin : g_c_reg
            logic [WIDTH-1:0] c_q;
            logic [WIDTH-1:0] c_d;
            assign c_d   = CEC ? C : c_q;
            assign c_eff = c_q;
            // C operand register
            always_ff @(posedge CLK or negedge RST)
                if (!RST) c_q <= '0;
                else      c_q <= c_d;
        end else begin : g_c_byp
            assign c_eff = C;
        end

        if (CARRYINREG) begin : g_cin_reg
            logic cin_q;
            logic cin_d;
            assign cin_d   = CECARRYIN ? CARRYIN : cin_q;
            assign cin_eff = cin_q;
            // carry-in register
            always_ff @(posedge CLK or negedge RST)
                if (!RST) cin_q <= 1'b0;
                else      cin_q <= cin_d;
        end else begin : g_cin_byp
            assign cin_eff = CARRYIN;
        end
    endgenerate

    // operand muxes; feedback always reads the visible P
    always_comb begin
        x = opmode_eff[1:0] == 2'd0 ? '0 :
            opmode_eff[1:0] == 2'd1 ? {{(WIDTH-M_WIDTH){1'b0}}, M} :
            opmode_eff[1:0] == 2'd2 ? P : DAB;
        z = opmode_eff[3:2] == 2'd0 ? '0 :
            opmode_eff[3:2] == 2'd1 ? PCIN :
            opmode_eff[3:2] == 2'd2 ? P : c_eff;
    end

    // WIDTH+1 bit add/subtract; the top bit is carry-out or borrow-out
    always_comb begin
        s = opmode_eff[7] ? {1'b0, z} - ({1'b0, x} + {{WIDTH{1'b0}}, cin_eff})
                          : {1'b0, z} + {1'b0, x} + {{WIDTH{1'b0}}, cin_eff};
    end

    generate
        if (PREG) begin : g_p_reg
            logic [WIDTH-1:0] p_q;
            logic [WIDTH-1:0] p_d;
            logic             co_q;
            logic             co_d;
            assign p_d = CEP ? s[WIDTH-1:0] : p_q;
            assign co_d = CEP ? s[WIDTH] : co_q;
            assign P = p_q;
            assign CARRYOUT = co_q;
            // result register; holding it freezes the accumulator
            always_ff @(posedge CLK or negedge RST)
                if (!RST) begin
                    p_q  <= '0;
                    co_q <= 1'b0;
                end else begin
                    p_q  <= p_d;
                    co_q <= co_d;
                end
        end else begin : g_p_byp
            assign P = s[WIDTH-1:0];
            assign CARRYOUT = s[WIDTH];
            // without the P register, selecting feedback closes a combinational loop
            always_comb
                assert (opmode_eff[1:0] != 2'd2 && opmode_eff[3:2] != 2'd2)
                    else $error("P feedback selected with PREG=0");
        end
    endgenerate

    assign PCOUT     = P;
    assign CARRYOUTF = CARRYOUT;
endmodule

// File: tb/tb_dsp_post_adder_acc.sv
// tb_dsp_post_adder_acc: vector table, corner sequences and random checks against an arithmetic model
module tb_dsp_post_adder_acc;
    logic        CLK;
    logic        RST;
    logic [35:0] M;
    logic [47:0] C;
    logic [47:0] PCIN;
    logic [47:0] DAB;
    logic        CARRYIN;
    logic [7:0]  OPMODE;
    logic        CEOPMODE;
    logic        CEC;
    logic        CECARRYIN;
    logic        CEP;
    logic [47:0] P;
    logic [47:0] PCOUT;
    logic        CARRYOUT;
    logic        CARRYOUTF;

    int tests = 0;
    int fails = 0;

    logic [7:0]  mop;
    logic [47:0] mc;
    logic        mcin;
    logic [47:0] mp;
    logic        mco;

    typedef struct {
        logic [7:0]  op;
        logic [35:0] m;
        logic [47:0] c;
        logic [47:0] pcin;
        logic [47:0] dab;
        logic        cin;
        logic [47:0] ep;
        logic        eco;
    } vec_t;

    vec_t tbl [9];

    dsp_post_adder_acc dut (
        .CLK(CLK), .RST(RST), .M(M), .C(C), .PCIN(PCIN), .DAB(DAB),
        .CARRYIN(CARRYIN), .OPMODE(OPMODE), .CEOPMODE(CEOPMODE), .CEC(CEC),
        .CECARRYIN(CECARRYIN), .CEP(CEP), .P(P), .PCOUT(PCOUT),
        .CARRYOUT(CARRYOUT), .CARRYOUTF(CARRYOUTF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [48:0] model_sum(input logic [7:0] op, input logic [35:0] m,
                                              input logic [47:0] c, input logic [47:0] pcin,
                                              input logic [47:0] dab, input logic [47:0] p,
                                              input logic cin);
        logic [48:0] xv;
        logic [48:0] zv;
        case (op[1:0])
            2'd0: xv = 0;
            2'd1: xv = {13'd0, m};
            2'd2: xv = {1'b0, p};
            default: xv = {1'b0, dab};
        endcase
        case (op[3:2])
            2'd0: zv = 0;
            2'd1: zv = {1'b0, pcin};
            2'd2: zv = {1'b0, p};
            default: zv = {1'b0, c};
        endcase
        return op[7] ? zv - (xv + 49'(cin)) : zv + xv + 49'(cin);
    endfunction

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " P"}, P, mp);
        chk({tag, " PCOUT"}, PCOUT, mp);
        chk({tag, " CARRYOUT"}, 48'(CARRYOUT), 48'(mco));
        chk({tag, " CARRYOUTF"}, 48'(CARRYOUTF), 48'(mco));
    endtask

    task automatic cyc(input string tag);
        logic [48:0] s;
        s = model_sum(mop, M, mc, PCIN, DAB, mp, mcin);
        @(posedge CLK);
        #1;
        if (CEP) begin
            mp  = s[47:0];
            mco = s[48];
        end
        if (CEOPMODE)  mop  = OPMODE;
        if (CEC)       mc   = C;
        if (CECARRYIN) mcin = CARRYIN;
        chk_model(tag);
    endtask

    task automatic model_clear();
        mop = '0; mc = '0; mcin = 1'b0; mp = '0; mco = 1'b0;
    endtask

    task automatic async_reset(input string tag);
        @(negedge CLK);
        RST = 1'b0;
        model_clear();
        #1;
        chk({tag, " async P"}, P, 48'd0);
        chk({tag, " async PCOUT"}, PCOUT, 48'd0);
        chk({tag, " async CARRYOUT"}, 48'(CARRYOUT), 48'd0);
        chk({tag, " async CARRYOUTF"}, 48'(CARRYOUTF), 48'd0);
        #2;
        RST = 1'b1;
    endtask

    task automatic set_all_ce(input logic v);
        CEOPMODE = v; CEC = v; CECARRYIN = v; CEP = v;
    endtask

    initial begin
        logic [63:0] r;
        RST = 1'b0;
        M = '0; C = '0; PCIN = '0; DAB = '0; CARRYIN = 1'b0; OPMODE = '0;
        set_all_ce(1'b1);
        model_clear();
        tbl[0] = '{8'h8D, 36'd5, 48'd3, 48'd0, 48'd0, 1'b0, 48'hFFFF_FFFF_FFFE, 1'b1};
        tbl[1] = '{8'h07, 36'd0, 48'd0, 48'd50, 48'd100, 1'b1, 48'd151, 1'b0};
        tbl[2] = '{8'h0D, 36'd234, 48'd1000, 48'd0, 48'd0, 1'b0, 48'd1234, 1'b0};
        tbl[3] = '{8'h8F, 36'd0, 48'd10, 48'd0, 48'd3, 1'b1, 48'd6, 1'b0};
        tbl[4] = '{8'h07, 36'd0, 48'd0, 48'd2, 48'hFFFF_FFFF_FFFF, 1'b0, 48'd1, 1'b1};
        tbl[5] = '{8'h01, 36'hF_FFFF_FFFF, 48'd0, 48'd0, 48'd0, 1'b1, 48'h10_0000_0000, 1'b0};
        tbl[6] = '{8'h84, 36'd0, 48'd0, 48'd0, 48'd0, 1'b1, 48'hFFFF_FFFF_FFFF, 1'b1};
        tbl[7] = '{8'h73, 36'd0, 48'd0, 48'd0, 48'hABC, 1'b0, 48'hABC, 1'b0};
        tbl[8] = '{8'h0F, 36'd0, 48'd5, 48'd0, 48'd7, 1'b1, 48'd13, 1'b0};
        #12;
        chk("reset P", P, 48'd0);
        RST = 1'b1;
        for (int i = 0; i < 9; i++) begin
            OPMODE = tbl[i].op; M = tbl[i].m; C = tbl[i].c; PCIN = tbl[i].pcin;
            DAB = tbl[i].dab; CARRYIN = tbl[i].cin;
            cyc($sformatf("vec%0d load", i));
            cyc($sformatf("vec%0d", i));
            chk($sformatf("vec%0d table P", i), P, tbl[i].ep);
            chk($sformatf("vec%0d table CARRYOUT", i), 48'(CARRYOUT), 48'(tbl[i].eco));
        end
        M = 36'h123; C = 48'h456; PCIN = 48'h789; DAB = 48'hABC; CARRYIN = 1'b1;
        async_reset("rst");
        OPMODE = 8'h0C; C = 48'd7; CARRYIN = 1'b0;
        cyc("rst rel1");
        chk("rst first edge P", P, 48'd0);
        cyc("rst rel2");
        chk("rst second edge P", P, 48'd7);
        async_reset("mac");
        OPMODE = 8'h09; M = 36'd5; CARRYIN = 1'b0;
        cyc("mac prep");
        for (int k = 1; k <= 4; k++) begin
            cyc("mac");
            chk($sformatf("mac step%0d", k), P, 48'(5 * k));
        end
        CEP = 1'b0;
        M = 36'd7; OPMODE = 8'h0D; C = 48'd99;
        cyc("hold1");
        cyc("hold2");
        chk("mac hold P", P, 48'd20);
        CEP = 1'b1;
        OPMODE = 8'h0C; C = 48'hFFFF_FFFF_FFFF; CARRYIN = 1'b0;
        cyc("wrap load1");
        cyc("wrap load2");
        chk("wrap preload P", P, 48'hFFFF_FFFF_FFFF);
        OPMODE = 8'h0E; C = 48'd1;
        cyc("wrap1");
        cyc("wrap2");
        chk("wrap P", P, 48'd0);
        chk("wrap CARRYOUT", 48'(CARRYOUT), 48'd1);
        async_reset("mid");
        OPMODE = 8'h09; M = 36'd5; CARRYIN = 1'b0;
        cyc("mid prep");
        cyc("mid a");
        cyc("mid b");
        chk("mid before reset P", P, 48'd10);
        async_reset("mid pulse");
        cyc("mid restart prep");
        cyc("mid restart");
        chk("mid restart P", P, 48'd5);
        for (int n = 0; n < 400; n++) begin
            r = {$urandom(), $urandom()};
            OPMODE = r[7:0];
            M = r[43:8];
            r = {$urandom(), $urandom()};
            C = r[47:0];
            r = {$urandom(), $urandom()};
            PCIN = ($urandom_range(0, 3) == 0) ? 48'hFFFF_FFFF_FFFF : r[47:0];
            r = {$urandom(), $urandom()};
            DAB = r[47:0];
            CARRYIN = 1'($urandom_range(0, 1));
            CEOPMODE = ($urandom_range(0, 4) != 0);
            CEC = ($urandom_range(0, 4) != 0);
            CECARRYIN = ($urandom_range(0, 4) != 0);
            CEP = ($urandom_range(0, 4) != 0);
            cyc("rand");
            if ($urandom_range(0, 99) == 0) async_reset("rand rst");
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
